// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard receiver (scan code set 2) producing A..Z letter codes 1..26,
// an Enter strobe and a framing-error strobe; typematic repeats are suppressed.
module ps2_letter_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [4:0] char,
   output logic       letter_valid,
   output logic       enter_pulse,
   output logic       frame_err
);

   // state  | meaning
   // IDLE   | waiting for a start bit (data low at a sample point)
   // DATA   | shifting in 8 data bits, LSB first
   // PARITY | capturing the parity bit
   // STOP   | checking stop bit and parity, then handing the byte over
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 1);

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_ENTER = 8'h5A;

   logic          clk_s1, clk_s2;
   logic          dat_s1, dat_s2;
   logic          filt_clk, filt_d;
   logic [FW-1:0] filt_cnt;
   logic          sample;

   logic [1:0]    state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;

   logic          stop_event;
   logic          frame_good;
   logic [4:0]    letter_code;

   logic          brk, ext;
   logic [7:0]    last_make;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_dat;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock follows only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         filt_clk <= 1'b1;
         filt_d   <= 1'b1;
         filt_cnt <= FILT_LOAD;
      end else begin
         filt_d <= filt_clk;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= FILT_LOAD;
         end else if (filt_cnt == '0) begin
            filt_clk <= clk_s2;
            filt_cnt <= FILT_LOAD;
         end else begin
            filt_cnt <= filt_cnt - 1'b1;
         end
      end
   end

   assign sample = filt_d & ~filt_clk;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         bitcnt  <= 3'd0;
         shreg   <= 8'h00;
         par_bit <= 1'b0;
         tmo_cnt <= TMO_LOAD;
      end else if (sample) begin
         tmo_cnt <= TMO_LOAD;
         case (state)
            ST_IDLE: begin
               if (!dat_s2) begin
                  state  <= ST_DATA;
                  bitcnt <= 3'd0;
               end
            end
            ST_DATA: begin
               shreg  <= {dat_s2, shreg[7:1]};
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) state <= ST_PARITY;
            end
            ST_PARITY: begin
               par_bit <= dat_s2;
               state   <= ST_STOP;
            end
            default: state <= ST_IDLE;
         endcase
      end else if (state != ST_IDLE) begin
         // Keyboard stopped clocking mid-frame: drop it without reporting.
         if (tmo_cnt == '0) state <= ST_IDLE;
         else               tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign stop_event = sample && (state == ST_STOP);
   assign frame_good = (^{shreg, par_bit}) & dat_s2;

   always_comb begin
      letter_code = 5'd0;
      case (shreg)
         8'h1C: letter_code = 5'd1;
         8'h32: letter_code = 5'd2;
         8'h21: letter_code = 5'd3;
         8'h23: letter_code = 5'd4;
         8'h24: letter_code = 5'd5;
         8'h2B: letter_code = 5'd6;
         8'h34: letter_code = 5'd7;
         8'h33: letter_code = 5'd8;
         8'h43: letter_code = 5'd9;
         8'h3B: letter_code = 5'd10;
         8'h42: letter_code = 5'd11;
         8'h4B: letter_code = 5'd12;
         8'h3A: letter_code = 5'd13;
         8'h31: letter_code = 5'd14;
         8'h44: letter_code = 5'd15;
         8'h4D: letter_code = 5'd16;
         8'h15: letter_code = 5'd17;
         8'h2D: letter_code = 5'd18;
         8'h1B: letter_code = 5'd19;
         8'h2C: letter_code = 5'd20;
         8'h3C: letter_code = 5'd21;
         8'h2A: letter_code = 5'd22;
         8'h1D: letter_code = 5'd23;
         8'h22: letter_code = 5'd24;
         8'h35: letter_code = 5'd25;
         8'h1A: letter_code = 5'd26;
         default: letter_code = 5'd0;
      endcase
   end

   // Pulses are registered, so they appear the cycle after the stop sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         char         <= 5'd0;
         letter_valid <= 1'b0;
         enter_pulse  <= 1'b0;
         frame_err    <= 1'b0;
         brk          <= 1'b0;
         ext          <= 1'b0;
         last_make    <= 8'h00;
      end else begin
         letter_valid <= 1'b0;
         enter_pulse  <= 1'b0;
         frame_err    <= 1'b0;
         if (stop_event) begin
            if (!frame_good) begin
               frame_err <= 1'b1;
            end else if (shreg == CODE_EXT) begin
               ext <= 1'b1;
            end else if (shreg == CODE_BRK) begin
               brk <= 1'b1;
            end else if (brk) begin
               if (!ext && (shreg == last_make)) last_make <= 8'h00;
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (ext) begin
               ext <= 1'b0;
            end else if (shreg == last_make) begin
               // typematic repeat of the key still held down
            end else if (letter_code != 5'd0) begin
               char         <= letter_code;
               letter_valid <= 1'b1;
               last_make    <= shreg;
            end else if (shreg == CODE_ENTER) begin
               enter_pulse <= 1'b1;
               last_make   <= shreg;
            end else begin
               last_make <= shreg;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Bench for ps2_letter_decoder: directed scenarios plus random byte streams
// compared against a byte-level model of the make/break/extended rules.
module tb_ps2_letter_decoder;

   localparam int FL   = 8;
   localparam int TO   = 2000;
   localparam int HALF = 20;

   logic       clk     = 1'b0;
   logic       resetn  = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [4:0] char;
   logic       letter_valid, enter_pulse, frame_err;

   ps2_letter_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .char(char), .letter_valid(letter_valid), .enter_pulse(enter_pulse),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // monitor, sampled on the falling clock edge
   int      n_lv = 0, n_en = 0, n_err = 0, n_multi = 0, n_wide = 0;
   longint  cyc = 0, last_lv_cyc = 0, stop_fall_cyc = 0;
   logic    p_lv = 1'b0, p_en = 1'b0, p_err = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (letter_valid) begin n_lv++; last_lv_cyc = cyc; end
      if (enter_pulse) n_en++;
      if (frame_err)   n_err++;
      if (int'(letter_valid) + int'(enter_pulse) + int'(frame_err) > 1) n_multi++;
      if ((letter_valid && p_lv) || (enter_pulse && p_en) || (frame_err && p_err)) n_wide++;
      p_lv = letter_valid; p_en = enter_pulse; p_err = frame_err;
   end

   // reference model
   logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [4:0] m_char = 5'd0;
   logic [7:0] m_last = 8'h00;
   bit         m_brk = 0, m_ext = 0;

   task automatic model_reset();
      m_char = 5'd0; m_last = 8'h00; m_brk = 0; m_ext = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good,
                             output int lv, output int en, output int er);
      int li;
      lv = 0; en = 0; er = 0; li = 0;
      for (int i = 0; i < 26; i++) if (letters[i] == b) li = i + 1;
      if (!good) er = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (m_brk) begin
         if (!m_ext && b == m_last) m_last = 8'h00;
         m_brk = 0; m_ext = 0;
      end else if (m_ext) m_ext = 0;
      else if (b == m_last) lv = 0;
      else begin
         m_last = b;
         if (li != 0) begin lv = 1; m_char = 5'(li); end
         else if (b == 8'h5A) en = 1;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         if (i == 10) stop_fall_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   task automatic do_frame(input string tag, input logic [7:0] b,
                           input bit bad_par = 0, input bit bad_stop = 0);
      int lv0, en0, er0, elv, een, eer;
      lv0 = n_lv; en0 = n_en; er0 = n_err;
      model_byte(b, !(bad_par || bad_stop), elv, een, eer);
      send_bits(frame_bits(b, bad_par, bad_stop), 11);
      wait_cyc(30);
      chk({tag, ".lv"},   n_lv - lv0,  elv);
      chk({tag, ".ent"},  n_en - en0,  een);
      chk({tag, ".err"},  n_err - er0, eer);
      chk({tag, ".char"}, char,        m_char);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      wait_cyc(3);
      resetn = 1'b1;
      model_reset();
      wait_cyc(5);
   endtask

   int lv_base;
   logic [7:0] rb;
   int r;
   bit bp, bs;

   initial begin
      wait_cyc(4);
      chk("rst.char", char, 5'd0);
      chk("rst.pulses", {letter_valid, enter_pulse, frame_err}, 3'b000);
      resetn = 1'b1;
      wait_cyc(5);

      // 1: single letter, latency from stop-bit fall
      do_frame("t1", 8'h1C);
      chk("t1.lat_ok", ((last_lv_cyc - stop_fall_cyc) >= 8) && ((last_lv_cyc - stop_fall_cyc) <= 16), 1);

      // 2: typematic suppression and release
      do_reset();
      lv_base = n_lv;
      do_frame("t2a", 8'h1C);
      do_frame("t2b", 8'h1C);
      do_frame("t2c", 8'h1C);
      do_frame("t2d", 8'hF0);
      do_frame("t2e", 8'h1C);
      do_frame("t2f", 8'h1C);
      chk("t2.total_lv", n_lv - lv_base, 2);
      chk("t2.char", char, 5'd1);

      // 3: parity error then good frame; then stop-bit error
      do_frame("t3a", 8'h1A, 1, 0);
      do_frame("t3b", 8'h35);
      chk("t3.char", char, 5'd25);
      do_frame("t3c", 8'h24, 0, 1);

      // 4: extended make/break and Enter
      do_frame("t4a", 8'hE0);
      do_frame("t4b", 8'h75);
      do_frame("t4c", 8'hE0);
      do_frame("t4d", 8'hF0);
      do_frame("t4e", 8'h75);
      do_frame("t4f", 8'h5A);

      // 5: aborted frame recovered by timeout
      send_bits(frame_bits(8'h3C, 0, 0), 5);
      wait_cyc(TO + 500);
      do_frame("t5", 8'h24);
      chk("t5.char", char, 5'd5);

      // 6: reset mid-frame, glitch rejection
      send_bits(frame_bits(8'h1D, 0, 0), 3);
      resetn = 1'b0;
      wait_cyc(3);
      chk("t6.rst_char", char, 5'd0);
      chk("t6.rst_pulses", {letter_valid, enter_pulse, frame_err}, 3'b000);
      resetn = 1'b1;
      model_reset();
      wait_cyc(20);
      ps2_dat = 1'b0;
      for (int g = 0; g < 6; g++) begin
         ps2_clk = 1'b0;
         wait_cyc(FL - 5 + (g % 3));
         ps2_clk = 1'b1;
         wait_cyc(12);
      end
      ps2_dat = 1'b1;
      wait_cyc(20);
      do_frame("t6", 8'h2C);
      chk("t6.char", char, 5'd20);

      // random byte stream
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      rb = letters[$urandom_range(0, 25)];
         else if (r < 55) rb = 8'hE0;
         else if (r < 65) rb = 8'hF0;
         else if (r < 70) rb = 8'h5A;
         else if (r < 80) rb = (m_last == 8'h00) ? 8'h1C : m_last;
         else             rb = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 99) < 8);
         bs = !bp && ($urandom_range(0, 99) < 4);
         do_frame($sformatf("rnd%0d", k), rb, bp, bs);
      end

      chk("overlap", n_multi, 0);
      chk("wide", n_wide, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
